// File: rtl/baud_rate_generator.sv
// Programmable UART baud-rate generator with divisor-latch semantics.
// Divides CLK by DIVISOR to produce a registered 16x baud clock, a baud tick
// enable and a bit-rate tick enable (one per OVERSAMPLE baud ticks).
module baud_rate_generator #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] DIVISOR,
  output logic             BAUDOUT_CLK,
  output logic             BAUD_TICK,
  output logic             BIT_TICK
);

  localparam int unsigned SubW = $clog2(OVERSAMPLE);
  localparam logic [SubW-1:0] SubMax = SubW'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [SubW-1:0]  sub_q, sub_d;
  logic             baud_clk_q, baud_clk_d;
  logic             baud_tick_q, baud_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic [DIV_W:0]   half;
  logic [DIV_W-1:0] div_m1;

  // Next-state for the divide counter, sub-counter and all registered outputs.
  always_comb begin
    half        = ({1'b0, DIVISOR} + (DIV_W + 1)'(1)) >> 1;
    div_m1      = DIVISOR - DIV_W'(1);
    cnt_d       = cnt_q;
    sub_d       = sub_q;
    baud_clk_d  = 1'b0;
    baud_tick_d = 1'b0;
    bit_tick_d  = 1'b0;

    if (DIVISOR == '0) begin
      // Disabled: park both counters so re-enabling restarts like a reset.
      cnt_d = '0;
      sub_d = '0;
    end else if (DIVISOR == DIV_W'(1)) begin
      cnt_d       = '0;
      baud_tick_d = 1'b1;
      baud_clk_d  = 1'b1;
    end else begin
      // ">=" lets a shrunken divisor wrap immediately instead of overrunning.
      if (cnt_q >= div_m1) begin
        cnt_d       = '0;
        baud_tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      // Odd divisors give the extra cycle to the high phase.
      baud_clk_d = ({1'b0, cnt_d} < half);
    end

    if (baud_tick_d) begin
      sub_d      = sub_q + SubW'(1);
      bit_tick_d = (sub_q == SubMax);
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= '0;
      sub_q       <= '0;
      baud_clk_q  <= 1'b0;
      baud_tick_q <= 1'b0;
      bit_tick_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      baud_clk_q  <= baud_clk_d;
      baud_tick_q <= baud_tick_d;
      bit_tick_q  <= bit_tick_d;
    end
  end

  assign BAUDOUT_CLK = baud_clk_q;
  assign BAUD_TICK   = baud_tick_q;
  assign BIT_TICK    = bit_tick_q;

endmodule

// File: tb/tb_baud_rate_generator.sv
// Directed bench for baud_rate_generator: expected waveforms come from the
// closed-form per-edge pattern (count = k mod D) and a running tick count.
module tb_baud_rate_generator;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] DIVISOR = 16'd3;
  logic        BAUDOUT_CLK;
  logic        BAUD_TICK;
  logic        BIT_TICK;

  int n_cmp  = 0;
  int n_err  = 0;
  int ntick  = 0;

  baud_rate_generator #(
    .DIV_W      (16),
    .OVERSAMPLE (16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .DIVISOR     (DIVISOR),
    .BAUDOUT_CLK (BAUDOUT_CLK),
    .BAUD_TICK   (BAUD_TICK),
    .BIT_TICK    (BIT_TICK)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  // Hold reset for n edges and confirm all outputs are low.
  task automatic do_reset(input int n);
    RST = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk("rst_clk", i, BAUDOUT_CLK, 1'b0);
      chk("rst_tick", i, BAUD_TICK, 1'b0);
      chk("rst_bit", i, BIT_TICK, 1'b0);
    end
    RST   = 1'b0;
    ntick = 0;
  endtask

  // Run n edges at divisor d; k0 is the expected count after the first edge.
  task automatic run(input int d, input int k0, input int n, input string tag);
    logic exp_tick, exp_bit, exp_clk;
    int   k;
    DIVISOR = d[15:0];
    for (int i = 0; i < n; i++) begin
      k = k0 + i;
      step();
      exp_tick = ((k % d) == 0);
      if (exp_tick) ntick++;
      exp_bit = exp_tick && ((ntick % 16) == 0);
      exp_clk = ((k % d) < ((d + 1) / 2));
      chk({tag, "_clk"}, k, BAUDOUT_CLK, exp_clk);
      chk({tag, "_tick"}, k, BAUD_TICK, exp_tick);
      chk({tag, "_bit"}, k, BIT_TICK, exp_bit);
    end
  endtask

  initial begin
    // Reset, then D=3: ticks on edges 3,6,9..., bit ticks on 48 and 96.
    do_reset(5);
    run(3, 1, 100, "d3");

    // 50% duty cases.
    do_reset(1);
    run(2, 1, 64, "d2");
    do_reset(1);
    run(4, 1, 64, "d4");

    // Pass-through rate: tick every cycle, bit tick every 16.
    do_reset(1);
    run(1, 1, 40, "d1");

    // Disabled: everything low, counters parked.
    DIVISOR = 16'd0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("d0_clk", i, BAUDOUT_CLK, 1'b0);
      chk("d0_tick", i, BAUD_TICK, 1'b0);
      chk("d0_bit", i, BIT_TICK, 1'b0);
    end
    ntick = 0;
    // Re-enable behaves like reset release.
    run(3, 1, 50, "d0to3");

    // Shrink divisor from 100 to 10 with count at 60: immediate wrap + tick.
    do_reset(1);
    run(100, 1, 60, "d100");
    run(10, 0, 160, "d10");

    // Mid-operation reset restarts the sequence identically.
    do_reset(1);
    run(5, 1, 37, "d5");
    do_reset(1);
    run(5, 1, 90, "d5rst");

    // Maximum divisor: long high phase, no early tick.
    do_reset(1);
    run(65535, 1, 10, "dmax");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/baud_rate_generator.md
Name: baud_rate_generator

Overview:
Programmable UART baud-rate generator, 16550-style divisor latch semantics. Divides the system clock CLK by a 16-bit DIVISOR and produces three outputs:
- a registered square-wave BAUDOUT_CLK at the 16x-oversampled baud rate;
- a one-cycle BAUD_TICK enable pulse at the same rate;
- a BIT_TICK pulse at the serial bit rate, once every OVERSAMPLE baud ticks.

It sits between the register file (divisor latch) and the UART TX/RX shifters, which use the tick enables rather than BAUDOUT_CLK as a clock.

Parameters:
- DIV_W, 16, width of DIVISOR and of the internal divide counter.
- OVERSAMPLE, 16, baud ticks per serial bit. Must be a power of two, from 2 to 256.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous reset, active-high.
- DIVISOR  input  DIV_W  clock divide ratio; may change at any time.
- BAUDOUT_CLK  output  1  registered divided clock, period = DIVISOR CLK cycles.
- BAUD_TICK  output  1  registered one-cycle pulse, once per DIVISOR cycles.
- BIT_TICK  output  1  registered one-cycle pulse, once per OVERSAMPLE baud ticks.

Behaviour:
- One clock domain only. The reset is synchronous and active-high: RST is sampled on the rising edge of CLK.
- All outputs are registered; there are no combinational paths from DIVISOR to the outputs.
- Reset (RST=1 at an edge): cnt=0, sub=0, BAUDOUT_CLK=0, BAUD_TICK=0, BIT_TICK=0. Reset overrides every other condition, including mid-period.
- Let D = DIVISOR sampled at the current edge and H = ceil(D/2) = (D+1)>>1.
- D = 0 (generator disabled):
  - cnt and sub held at 0;
  - all outputs driven 0.
- D = 1 (pass-through rate):
  - cnt held at 0; BAUD_TICK=1 every cycle; BAUDOUT_CLK=1 constant.
  - sub increments every cycle.
- D >= 2, per edge:
  - if cnt >= D-1: cnt<=0, BAUD_TICK<=1;
  - else: cnt<=cnt+1, BAUD_TICK<=0.
  - The ">=" comparison absorbs a DIVISOR reduction below the current count: the counter wraps on the next edge with a tick, with no long overrun.
- BAUDOUT_CLK (D >= 2) is registered as (cnt_next < H).
  - High for H cycles, low for D-H cycles.
  - High phase starts at count 0; odd D gives the extra cycle to the high phase.
- First period after reset release (D >= 2): the first edge with RST=0 loads cnt=1, BAUDOUT_CLK=1. The first BAUD_TICK is registered on the D-th edge after reset release.
- BIT_TICK:
  - sub is a log2(OVERSAMPLE)-bit counter that advances only on edges where BAUD_TICK is being registered 1.
  - BIT_TICK<=1 on the edge where sub wraps from OVERSAMPLE-1 to 0; otherwise 0.
  - BIT_TICK is always coincident with a BAUD_TICK pulse.
- DIVISOR change mid-period:
  - the new value takes effect at the next edge;
  - no reset of cnt or sub, except the wrap rule above;
  - changing to 0 clears cnt and sub and forces the outputs low on the next edge.
- Counter width is DIV_W. D = 2^DIV_W-1 is the maximum period; there is no overflow because cnt never exceeds D-1.
- No X propagation: all registers are reset; DIVISOR is the only data input.

Test Plan:
- Reset then period, D=3: 10 ns CLK, RST=1 for 5 cycles, then 0.
  - BAUD_TICK pulses on the 3rd, 6th, 9th... edges after release.
  - BAUDOUT_CLK pattern per edge from release: 1,0,1,1,0,1,1,0... (period 3: 2 high, 1 low).
  - BIT_TICK first pulses on the 48th edge, then every 48 cycles.
- D=2 and D=4: BAUDOUT_CLK is a 50% duty wave of period 2 and 4 cycles respectively; BAUD_TICK fires every 2 and 4 cycles.
- D=0: all outputs stay 0 indefinitely. Switching to D=3 starts the sequence exactly as after reset (first tick on the 3rd edge).
- D=1: BAUD_TICK=1 and BAUDOUT_CLK=1 every cycle; BIT_TICK pulses every 16 cycles.
- Divisor change: D=100 running, cnt=60, DIVISOR set to 10.
  - Next edge: cnt=0 with BAUD_TICK=1.
  - Thereafter ticks every 10 cycles, 5 high and 5 low.
- Mid-operation reset: assert RST for 1 cycle at an arbitrary cnt/sub.
  - Next edge: all outputs 0, counters 0.
  - The sequence restarts identically to the post-reset case.
